// File: rtl/obstacle_pkg.sv
// Shared types and default geometry for the obstacle scroll controller.
// lane_offset() gives each lane's staggered start position.
package obstacle_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } scroll_state_t;

  localparam int unsigned DEF_POS_MAX     = 680;
  localparam int unsigned DEF_LANE_OFFSET = 170;
  localparam int unsigned DEF_LEVEL_TICKS = 1800;

  function automatic int unsigned lane_offset(input int unsigned i,
                                              input int unsigned offset  = DEF_LANE_OFFSET,
                                              input int unsigned pos_max = DEF_POS_MAX);
    return (i * offset) % pos_max;
  endfunction

endpackage

// File: rtl/obstacle_scroll_ctrl_if.sv
// Control/status bundle between the game FSM (master) and the scroll controller (slave).
interface obstacle_scroll_ctrl_if #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned POS_W     = 10,
  parameter int unsigned TIME_W    = 16,
  parameter int unsigned LVL_W     = 4
) ();

  // There is no valid/ready pair here: every control is sampled on each clock edge,
  // every status output is registered, and level_done/wrap_pulse are one-cycle pulses.
  logic                         menu_screen;
  logic                         player_won;
  logic                         player_lost;
  logic                         start;
  logic                         pause;
  logic [NUM_LANES-1:0]         lane_reset;
  logic [NUM_LANES*POS_W-1:0]   obj_position;
  logic [NUM_LANES-1:0]         wrap_pulse;
  logic [TIME_W-1:0]            game_time;
  logic [LVL_W-1:0]             level;
  logic                         level_done;
  logic                         running;
  obstacle_pkg::scroll_state_t  state;

  modport master (
    output menu_screen, player_won, player_lost, start, pause, lane_reset,
    input  obj_position, wrap_pulse, game_time, level, level_done, running, state
  );

  modport slave (
    input  menu_screen, player_won, player_lost, start, pause, lane_reset,
    output obj_position, wrap_pulse, game_time, level, level_done, running, state
  );

endinterface

// File: rtl/lane_pos_counter.sv
// One obstacle lane: position register with offset load, wrap/restart to 0 and wrap pulse.
module lane_pos_counter #(
  parameter int unsigned POS_W   = 10,
  parameter int unsigned POS_MAX = 680,
  parameter int unsigned OFFSET  = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             advance,
  input  logic             restart,
  input  logic [POS_W-1:0] step,
  output logic [POS_W-1:0] pos,
  output logic             wrap_pulse
);

  localparam logic [POS_W-1:0] OFF   = POS_W'(OFFSET);
  localparam logic [POS_W-1:0] LIMIT = POS_W'(POS_MAX);

  // The carry bit cannot be set: the top rejects POS_MAX+MAX_STEP >= 2**POS_W.
  logic [POS_W:0] sum;
  logic           unused_carry;
  assign sum          = {1'b0, pos} + {1'b0, step};
  assign unused_carry = sum[POS_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos        <= OFF;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (load) begin
        pos <= OFF;
      end else if (advance) begin
        if (pos >= LIMIT || restart) begin
          pos        <= '0;
          wrap_pulse <= 1'b1;
        end else begin
          pos <= sum[POS_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/obstacle_scroll_ctrl.sv
// Multi-lane obstacle scroll controller: IDLE/RUN/PAUSE FSM, level timer and level counter.
// Define SCROLL_SPEED_RAMP_EN to make the scroll step grow with the level.
module obstacle_scroll_ctrl
  import obstacle_pkg::*;
#(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned POS_W       = 10,
  parameter int unsigned POS_MAX     = DEF_POS_MAX,
  parameter int unsigned LANE_OFFSET = DEF_LANE_OFFSET,
  parameter int unsigned BASE_STEP   = 5,
  parameter int unsigned MAX_STEP    = 15,
  parameter int unsigned TIME_W      = 16,
  parameter int unsigned LEVEL_TICKS = DEF_LEVEL_TICKS,
  parameter int unsigned LVL_W       = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  obstacle_scroll_ctrl_if.slave bus
);

  if (POS_MAX + MAX_STEP >= 2**POS_W) begin : g_bad_params
    $error("obstacle_scroll_ctrl: POS_MAX + MAX_STEP must stay below 2**POS_W");
  end

  scroll_state_t     state_q;
  logic [TIME_W-1:0] game_time_q;
  logic [LVL_W-1:0]  level_q;
  logic              level_done_q;
  logic              running_q;

  logic abort, advance, level_end, lane_load, lane_step_en;
  assign abort        = bus.menu_screen | bus.player_won | bus.player_lost;
  assign advance      = (state_q == RUN) && !bus.pause && !abort;
  assign level_end    = advance && (game_time_q == TIME_W'(LEVEL_TICKS - 1));
  assign lane_load    = abort || level_end;
  assign lane_step_en = advance && !level_end;

  logic [POS_W-1:0] step;
`ifdef SCROLL_SPEED_RAMP_EN
  logic [POS_W:0] ramp;
  assign ramp = (POS_W+1)'(BASE_STEP) + (POS_W+1)'(level_q);
  assign step = (ramp > (POS_W+1)'(MAX_STEP)) ? POS_W'(MAX_STEP) : ramp[POS_W-1:0];
`else
  assign step = POS_W'(BASE_STEP);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      game_time_q  <= '0;
      level_q      <= '0;
      level_done_q <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      level_done_q <= 1'b0;
      if (abort) begin
        state_q     <= IDLE;
        game_time_q <= '0;
        level_q     <= '0;
        running_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (bus.start) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
          RUN: begin
            if (bus.pause) begin
              state_q   <= PAUSE;
              running_q <= 1'b0;
            end else if (level_end) begin
              level_done_q <= 1'b1;
              game_time_q  <= '0;
              if (level_q != {LVL_W{1'b1}}) level_q <= level_q + 1'b1;
            end else begin
              game_time_q <= game_time_q + 1'b1;
            end
          end
          PAUSE: if (!bus.pause) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
          default: begin
            state_q   <= IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  logic [POS_W-1:0]     lane_pos [NUM_LANES];
  logic [NUM_LANES-1:0] lane_wrap;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_pos_counter #(
      .POS_W   (POS_W),
      .POS_MAX (POS_MAX),
      .OFFSET  (lane_offset(i, LANE_OFFSET, POS_MAX))
    ) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (lane_load),
      .advance    (lane_step_en),
      .restart    (bus.lane_reset[i]),
      .step       (step),
      .pos        (lane_pos[i]),
      .wrap_pulse (lane_wrap[i])
    );
    assign bus.obj_position[i*POS_W +: POS_W] = lane_pos[i];
  end

  assign bus.wrap_pulse = lane_wrap;
  assign bus.game_time  = game_time_q;
  assign bus.level      = level_q;
  assign bus.level_done = level_done_q;
  assign bus.running    = running_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_obstacle_scroll_ctrl.sv
// Bench for obstacle_scroll_ctrl: spec-level model feeding a scoreboard, plus per-scenario checks.
module tb_obstacle_scroll_ctrl;
  import obstacle_pkg::*;

  localparam int NL = 4;
  localparam int PW = 10;
  localparam int TW = 16;
  localparam int LW = 4;
  localparam int W  = 2 + NL*PW + NL + TW + LW + 2;
`ifdef SCROLL_SPEED_RAMP_EN
  localparam int STEP_L1  = 6;
  localparam int STEP_L15 = 15;
`else
  localparam int STEP_L1  = 5;
  localparam int STEP_L15 = 5;
`endif
  localparam logic [NL*PW-1:0] OFFS_PACKED = {10'd510, 10'd340, 10'd170, 10'd0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  obstacle_scroll_ctrl_if #(.NUM_LANES(NL), .POS_W(PW), .TIME_W(TW), .LVL_W(LW)) bus ();

  obstacle_scroll_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  int            offs [NL] = '{0, 170, 340, 510};
  scroll_state_t m_state;
  int            m_pos [NL];
  int            m_gt, m_lvl;
  bit            m_done, m_run;
  bit [NL-1:0]   m_wrap;

  function automatic int step_for(input int lvl);
`ifdef SCROLL_SPEED_RAMP_EN
    return (5 + lvl > 15) ? 15 : 5 + lvl;
`else
    return 5 + 0 * lvl;
`endif
  endfunction

  function automatic void model_reset();
    m_state = IDLE;
    for (int i = 0; i < NL; i++) m_pos[i] = offs[i];
    m_gt = 0; m_lvl = 0; m_done = 0; m_run = 0; m_wrap = '0;
  endfunction

  function automatic void model_step();
    int st;
    st = step_for(m_lvl);
    m_done = 0;
    m_wrap = '0;
    if (bus.menu_screen || bus.player_won || bus.player_lost) begin
      m_state = IDLE; m_gt = 0; m_lvl = 0; m_run = 0;
      for (int i = 0; i < NL; i++) m_pos[i] = offs[i];
    end else begin
      case (m_state)
        IDLE: if (bus.start) begin m_state = RUN; m_run = 1; end
        RUN: begin
          if (bus.pause) begin
            m_state = PAUSE; m_run = 0;
          end else if (m_gt == 1799) begin
            m_done = 1; m_gt = 0;
            if (m_lvl < 15) m_lvl++;
            for (int i = 0; i < NL; i++) m_pos[i] = offs[i];
          end else begin
            for (int i = 0; i < NL; i++) begin
              if (m_pos[i] >= 680 || bus.lane_reset[i]) begin
                m_pos[i] = 0; m_wrap[i] = 1'b1;
              end else begin
                m_pos[i] = m_pos[i] + st;
              end
            end
            m_gt++;
          end
        end
        default: if (!bus.pause) begin m_state = RUN; m_run = 1; end
      endcase
    end
  endfunction

  function automatic logic [W-1:0] pack_model();
    logic [NL*PW-1:0] pv;
    for (int i = 0; i < NL; i++) pv[i*PW +: PW] = PW'(m_pos[i]);
    return {m_state, pv, m_wrap, TW'(m_gt), LW'(m_lvl), m_done, m_run};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_exp, sb_got;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      sb_got = {bus.state, bus.obj_position, bus.wrap_pulse, bus.game_time,
                bus.level, bus.level_done, bus.running};
      n_tests++;
      if (sb_got !== sb_exp) begin
        n_fail++;
        $display("FAIL sb_cycle t=%0t got=%h exp=%h", $time, sb_got, sb_exp);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    model_step();
    exp_q.push_back(pack_model());
    @(posedge clk);
    #2;
  endtask

  function automatic int lane(input int i);
    return int'(bus.obj_position[i*PW +: PW]);
  endfunction

  task automatic run_to_gt(input int target);
    for (int k = 0; k < 4000 && m_gt != target; k++) tick();
    n_tests++;
    if (bus.game_time !== TW'(target)) begin
      n_fail++;
      $display("FAIL run_to_gt got=%0d exp=%0d", bus.game_time, target);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (bus.obj_position !== OFFS_PACKED || bus.running !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held pos=%h run=%b exp pos=%h run=0", bus.obj_position, bus.running, OFFS_PACKED);
    end
    reset_n = 1'b1;
    model_reset();
    bus.pause = 1'b1;
    tick();
    bus.pause = 1'b0;
    n_tests++;
    if (bus.obj_position !== OFFS_PACKED) begin
      n_fail++;
      $display("FAIL reset_pos got=%h exp=%h", bus.obj_position, OFFS_PACKED);
    end
    n_tests++;
    if (bus.level !== 4'd0 || bus.game_time !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_counters level=%0d gt=%0d exp 0/0", bus.level, bus.game_time);
    end
    n_tests++;
    if (bus.running !== 1'b0 || bus.wrap_pulse !== 4'b0 || bus.level_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags run=%b wrap=%b done=%b exp 0", bus.running, bus.wrap_pulse, bus.level_done);
    end
  endtask

  task automatic test_scroll_wrap();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_tests++;
    if (bus.running !== 1'b1 || lane(0) !== 0) begin
      n_fail++;
      $display("FAIL start_run run=%b lane0=%0d exp 1/0", bus.running, lane(0));
    end
    repeat (136) tick();
    n_tests++;
    if (lane(0) !== 680) begin
      n_fail++;
      $display("FAIL lane0_at_max got=%0d exp=680", lane(0));
    end
    tick();
    n_tests++;
    if (lane(0) !== 0 || bus.wrap_pulse[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL lane0_wrap pos=%0d wrap=%b exp 0/1", lane(0), bus.wrap_pulse[0]);
    end
    tick();
    n_tests++;
    if (lane(0) !== 5 || bus.wrap_pulse[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL lane0_after_wrap pos=%0d wrap=%b exp 5/0", lane(0), bus.wrap_pulse[0]);
    end
    repeat (2) tick();
    n_tests++;
    if (bus.game_time !== 16'd140 || lane(0) !== 15) begin
      n_fail++;
      $display("FAIL run_140 gt=%0d lane0=%0d exp 140/15", bus.game_time, lane(0));
    end
  endtask

  task automatic test_pause();
    bus.pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_tests++;
      if (lane(0) !== 15 || bus.game_time !== 16'd140 || bus.running !== 1'b0) begin
        n_fail++;
        $display("FAIL pause_frozen k=%0d lane0=%0d gt=%0d run=%b exp 15/140/0", k, lane(0), bus.game_time, bus.running);
      end
    end
    bus.pause = 1'b0;
    tick();
    tick();
    n_tests++;
    if (lane(0) !== 20 || bus.game_time !== 16'd141) begin
      n_fail++;
      $display("FAIL pause_resume lane0=%0d gt=%0d exp 20/141", lane(0), bus.game_time);
    end
  endtask

  task automatic test_level();
    run_to_gt(1799);
    tick();
    n_tests++;
    if (bus.level_done !== 1'b1 || bus.level !== 4'd1 || bus.game_time !== 16'd0) begin
      n_fail++;
      $display("FAIL level_complete done=%b level=%0d gt=%0d exp 1/1/0", bus.level_done, bus.level, bus.game_time);
    end
    n_tests++;
    if (bus.obj_position !== OFFS_PACKED || bus.wrap_pulse !== 4'b0) begin
      n_fail++;
      $display("FAIL level_offsets pos=%h wrap=%b exp %h/0", bus.obj_position, bus.wrap_pulse, OFFS_PACKED);
    end
    tick();
    n_tests++;
    if (bus.level_done !== 1'b0 || lane(0) !== STEP_L1 || lane(1) !== 170 + STEP_L1) begin
      n_fail++;
      $display("FAIL level1_step done=%b lane0=%0d lane1=%0d exp step %0d", bus.level_done, lane(0), lane(1), STEP_L1);
    end
  endtask

  task automatic test_abort_collision();
    run_to_gt(1799);
    bus.player_lost = 1'b1;
    bus.lane_reset  = 4'b0100;
    tick();
    bus.player_lost = 1'b0;
    bus.lane_reset  = 4'b0000;
    n_tests++;
    if (bus.running !== 1'b0 || bus.level !== 4'd0 || bus.game_time !== 16'd0) begin
      n_fail++;
      $display("FAIL abort_counters run=%b level=%0d gt=%0d exp 0/0/0", bus.running, bus.level, bus.game_time);
    end
    n_tests++;
    if (bus.level_done !== 1'b0 || bus.wrap_pulse !== 4'b0 || bus.obj_position !== OFFS_PACKED) begin
      n_fail++;
      $display("FAIL abort_pulses done=%b wrap=%b pos=%h exp 0/0/%h", bus.level_done, bus.wrap_pulse, bus.obj_position, OFFS_PACKED);
    end
  endtask

  task automatic test_lane_reset();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (26) tick();
    n_tests++;
    if (lane(1) !== 300) begin
      n_fail++;
      $display("FAIL lane1_at_300 got=%0d exp=300", lane(1));
    end
    bus.lane_reset = 4'b0010;
    tick();
    bus.lane_reset = 4'b0000;
    n_tests++;
    if (lane(1) !== 0 || bus.wrap_pulse !== 4'b0010) begin
      n_fail++;
      $display("FAIL lane1_restart pos=%0d wrap=%b exp 0/0010", lane(1), bus.wrap_pulse);
    end
    n_tests++;
    if (lane(0) !== 135 || lane(2) !== 475 || lane(3) !== 645) begin
      n_fail++;
      $display("FAIL other_lanes l0=%0d l2=%0d l3=%0d exp 135/475/645", lane(0), lane(2), lane(3));
    end
  endtask

  task automatic test_level_sat();
    for (int l = 0; l < 16; l++) begin
      run_to_gt(1799);
      tick();
    end
    n_tests++;
    if (bus.level !== 4'd15 || bus.level_done !== 1'b1) begin
      n_fail++;
      $display("FAIL level_saturate level=%0d done=%b exp 15/1", bus.level, bus.level_done);
    end
    tick();
    n_tests++;
    if (lane(0) !== STEP_L15 || lane(2) !== 340 + STEP_L15) begin
      n_fail++;
      $display("FAIL step_cap lane0=%0d lane2=%0d exp step %0d", lane(0), lane(2), STEP_L15);
    end
  endtask

  task automatic test_async_reset();
    repeat (7) tick();
    #1;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (bus.obj_position !== OFFS_PACKED || bus.level !== 4'd0 ||
        bus.running !== 1'b0 || bus.game_time !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset pos=%h level=%0d run=%b gt=%0d exp offsets/0/0/0",
               bus.obj_position, bus.level, bus.running, bus.game_time);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (lane(0) !== 15 || bus.running !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_after_reset lane0=%0d run=%b exp 15/1", lane(0), bus.running);
    end
  endtask

  initial begin
    bus.menu_screen = 1'b0;
    bus.player_won  = 1'b0;
    bus.player_lost = 1'b0;
    bus.start       = 1'b0;
    bus.pause       = 1'b0;
    bus.lane_reset  = '0;
    model_reset();
    test_reset();
    test_scroll_wrap();
    test_pause();
    test_level();
    test_abort_collision();
    test_lane_reset();
    test_level_sat();
    test_async_reset();
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain left=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
